// File: rtl/rps_pkg.sv
// Shared codes for the rock-paper-scissors judge: result and choice encodings,
// round FSM states, legal key range and the outcome rule.
package rps_pkg;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_A    = 2'b01,
    RES_B    = 2'b10,
    RES_DRAW = 2'b11
  } res_t;

  typedef enum logic [1:0] {
    ROCK     = 2'd0,
    SCISSORS = 2'd1,
    PAPER    = 2'd2
  } choice_t;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    JUDGE,
    SHOW,
    OVER
  } state_t;

  localparam logic [3:0] KEY_MIN = 4'd1;
  localparam logic [3:0] KEY_MAX = 4'd9;

  // d = (ib - ia) mod 3; each pick beats the next one in ROCK, SCISSORS, PAPER order
  function automatic logic [1:0] rps_outcome(input logic [1:0] ia, input logic [1:0] ib);
    logic [1:0] d;
    d = (ib >= ia) ? (ib - ia) : (ib + 2'd3 - ia);
    case (d)
      2'd0:    rps_outcome = RES_DRAW;
      2'd1:    rps_outcome = RES_A;
      default: rps_outcome = RES_B;
    endcase
  endfunction

endpackage

// File: rtl/rps_key_decode.sv
// Combinational decode of the guess-state key into both picks and the round outcome.
module rps_key_decode
  import rps_pkg::*;
(
  input  logic [3:0] key,
  output logic       valid,
  output logic [1:0] ia,
  output logic [1:0] ib,
  output logic [1:0] outcome
);

  always_comb begin
    valid = (key >= KEY_MIN) && (key <= KEY_MAX);
    {ia, ib} = {ROCK, ROCK};
    case (key)
      4'd1: {ia, ib} = {ROCK, ROCK};
      4'd2: {ia, ib} = {ROCK, SCISSORS};
      4'd3: {ia, ib} = {ROCK, PAPER};
      4'd4: {ia, ib} = {SCISSORS, ROCK};
      4'd5: {ia, ib} = {SCISSORS, SCISSORS};
      4'd6: {ia, ib} = {SCISSORS, PAPER};
      4'd7: {ia, ib} = {PAPER, ROCK};
      4'd8: {ia, ib} = {PAPER, SCISSORS};
      4'd9: {ia, ib} = {PAPER, PAPER};
      default: ;
    endcase
    outcome = valid ? rps_outcome(ia, ib) : RES_NONE;
  end

endmodule

// File: rtl/rps_round_judge.sv
// Round sequencer and scorekeeper for the rock-paper-scissors game.
// Optional RPS_ROUND_HIST_EN adds hist[15:0], the last 8 results (newest in [1:0]).
module rps_round_judge
  import rps_pkg::*;
#(
  parameter int WIN_SCORE = 3,
  parameter int SHOW_CYC  = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  input  logic       ready,
  input  logic       start,
  output logic [3:0] score_a,
  output logic [3:0] score_b,
  output logic [1:0] result,
  output logic [3:0] round_cnt,
  output logic       armed,
  output logic       invalid,
  output logic       game_over,
  output logic [1:0] winner
`ifdef RPS_ROUND_HIST_EN
  ,
  output logic [15:0] hist
`endif
);

  localparam int TW = (SHOW_CYC > 1) ? $clog2(SHOW_CYC) : 1;
  localparam logic [TW-1:0] SHOW_LAST = TW'(SHOW_CYC - 1);
  localparam logic [3:0]    WIN       = 4'(WIN_SCORE);

  state_t          state, state_n;
  logic [3:0]      key_q;
  logic [3:0]      dec_key;
  logic            dec_valid;
  logic [1:0]      dec_out;
  logic [3:0]      dec_unused;
  logic [3:0]      sa_n, sb_n;
  logic [TW-1:0]   timer;

  // The live key is decoded for validity while ARMED; the latched key is judged in JUDGE.
  assign dec_key = (state == JUDGE) ? key_q : key;

  rps_key_decode u_decode (
    .key     (dec_key),
    .valid   (dec_valid),
    .ia      (dec_unused[3:2]),
    .ib      (dec_unused[1:0]),
    .outcome (dec_out)
  );

  always_comb begin
    state_n = state;
    sa_n    = (dec_out == RES_A) ? score_a + 4'd1 : score_a;
    sb_n    = (dec_out == RES_B) ? score_b + 4'd1 : score_b;
    case (state)
      IDLE:    if (ready) state_n = ARMED;
      ARMED:   if (start && dec_valid) state_n = JUDGE;
      JUDGE:   state_n = ((sa_n == WIN) || (sb_n == WIN)) ? OVER : SHOW;
      SHOW:    if (ready && (timer >= SHOW_LAST)) state_n = ARMED;
      OVER:    ;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      key_q     <= 4'd0;
      score_a   <= 4'd0;
      score_b   <= 4'd0;
      result    <= RES_NONE;
      round_cnt <= 4'd0;
      invalid   <= 1'b0;
      winner    <= RES_NONE;
      timer     <= '0;
`ifdef RPS_ROUND_HIST_EN
      hist      <= 16'd0;
`endif
    end else begin
      state   <= state_n;
      invalid <= (state == ARMED) && start && !dec_valid;
      if ((state == ARMED) && start && dec_valid) key_q <= key;
      if (state == JUDGE) begin
        score_a <= sa_n;
        score_b <= sb_n;
        result  <= dec_out;
        if (round_cnt != 4'hF) round_cnt <= round_cnt + 4'd1;
        if (state_n == OVER) winner <= dec_out;
`ifdef RPS_ROUND_HIST_EN
        hist <= {hist[13:0], dec_out};
`endif
      end
      // Timer restarts on every SHOW entry and saturates once ready may be accepted.
      if (state != SHOW) timer <= '0;
      else if (timer < SHOW_LAST) timer <= timer + 1'b1;
    end
  end

  assign armed     = (state == ARMED);
  assign game_over = (state == OVER);

endmodule

// File: tb/tb_rps_round_judge.sv
// Self-checking bench for rps_round_judge against a round-level reference model.
module tb_rps_round_judge;

  localparam int WIN = 3;
  localparam int SC  = 6;
  localparam int M_IDLE = 0, M_ARMED = 1, M_JUDGE = 2, M_SHOW = 3, M_OVER = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic       start = 1'b0;
  logic [3:0] key = 4'd0;
  logic [3:0] score_a, score_b, round_cnt;
  logic [1:0] result, winner;
  logic       armed, invalid, game_over;
`ifdef RPS_ROUND_HIST_EN
  logic [15:0] hist;
`endif

  rps_round_judge #(.WIN_SCORE(WIN), .SHOW_CYC(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .key       (key),
    .ready     (ready),
    .start     (start),
    .score_a   (score_a),
    .score_b   (score_b),
    .result    (result),
    .round_cnt (round_cnt),
    .armed     (armed),
    .invalid   (invalid),
    .game_over (game_over),
    .winner    (winner)
`ifdef RPS_ROUND_HIST_EN
    ,
    .hist      (hist)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_mode, m_kq, m_sa, m_sb, m_res, m_rounds, m_inv, m_win, m_cnt;
  logic [15:0] m_hist;

  wire [18:0] dut_obs = {score_a, score_b, result, round_cnt, armed, invalid, game_over, winner};

  function automatic logic [18:0] m_exp();
    return {4'(m_sa), 4'(m_sb), 2'(m_res), 4'(m_rounds), (m_mode == M_ARMED),
            1'(m_inv), (m_mode == M_OVER), 2'(m_win)};
  endfunction

  function automatic void model_clear();
    m_mode = M_IDLE; m_kq = 0; m_sa = 0; m_sb = 0; m_res = 0;
    m_rounds = 0; m_inv = 0; m_win = 0; m_cnt = 0; m_hist = 16'd0;
  endfunction

  function automatic void model_step(input logic r, input logic s, input logic [3:0] k);
    int ia, ib, d, res;
    m_inv = 0;
    case (m_mode)
      M_IDLE:  if (r) m_mode = M_ARMED;
      M_ARMED: if (s) begin
        if (k >= 1 && k <= 9) begin m_kq = int'(k); m_mode = M_JUDGE; end
        else m_inv = 1;
      end
      M_JUDGE: begin
        ia = (m_kq - 1) / 3;
        ib = (m_kq - 1) % 3;
        d = (ib - ia + 3) % 3;
        res = (d == 0) ? 3 : (d == 1) ? 1 : 2;
        if (res == 1) m_sa++;
        if (res == 2) m_sb++;
        m_res = res;
        if (m_rounds < 15) m_rounds++;
        m_hist = {m_hist[13:0], 2'(res)};
        if (m_sa == WIN || m_sb == WIN) begin m_mode = M_OVER; m_win = res; end
        else begin m_mode = M_SHOW; m_cnt = 0; end
      end
      M_SHOW: if (r && m_cnt >= SC - 1) m_mode = M_ARMED; else m_cnt++;
      default: ;
    endcase
  endfunction

  task automatic tick(input logic r, input logic s, input logic [3:0] k);
    ready = r; start = s; key = k;
    @(posedge clk);
    model_step(r, s, k);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; start = 1'b0; key = 4'd0;
    @(posedge clk);
    model_clear();
    #1;
    rst = 1'b0;
  endtask

  task automatic arm();
    for (int i = 0; i < SC + 4 && m_mode != M_ARMED; i++) tick(1'b1, 1'b0, 4'd0);
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (dut_obs !== 19'd0) begin n_bad++; $display("FAIL reset_state: got %h want %h", dut_obs, 19'd0); end
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b1, 4'd2);
    do_reset();
    n_cmp++;
    if (dut_obs !== 19'd0) begin n_bad++; $display("FAIL reset_mid_round: got %h want %h", dut_obs, 19'd0); end
    tick(1'b1, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    tick(1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (dut_obs !== m_exp() || score_a !== 4'd0 || armed !== 1'b1) begin
      n_bad++; $display("FAIL reset_discard_key: got %h want %h", dut_obs, m_exp());
    end
  endtask

  task automatic test_a_wins();
    do_reset();
    tick(1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (armed !== 1'b1) begin n_bad++; $display("FAIL armed_after_ready: got %b want 1", armed); end
    tick(1'b0, 1'b1, 4'd2);
    n_cmp++;
    if ({result, score_a} !== 6'd0) begin n_bad++; $display("FAIL a_win_early: got %h want 0", {result, score_a}); end
    tick(1'b0, 1'b0, 4'd7);
    n_cmp++;
    if ({result, score_a, score_b, round_cnt} !== {2'b01, 4'd1, 4'd0, 4'd1}) begin
      n_bad++; $display("FAIL a_win_result: got %h want %h", {result, score_a, score_b, round_cnt}, {2'b01, 4'd1, 4'd0, 4'd1});
    end
  endtask

  task automatic test_show_hold();
    for (int i = 0; i < SC - 2; i++) tick(1'b0, 1'b0, 4'd0);
    tick(1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (armed !== 1'b0) begin n_bad++; $display("FAIL show_early_ready: got %b want 0", armed); end
    tick(1'b1, 1'b0, 4'd0);
    n_cmp++;
    if (armed !== 1'b1) begin n_bad++; $display("FAIL show_ready_ok: got %b want 1", armed); end
  endtask

  task automatic test_draws();
    logic [3:0] keys [2] = '{4'd5, 4'd9};
    for (int r = 0; r < 2; r++) begin
      arm();
      tick(1'b0, 1'b1, keys[r]);
      tick(1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (result !== 2'b11 || {score_a, score_b} !== {4'd1, 4'd0} || round_cnt !== 4'(2 + r)) begin
        n_bad++; $display("FAIL draw_%0d: got %h want %h", r, {result, score_a, score_b, round_cnt}, {2'b11, 4'd1, 4'd0, 4'(2 + r)});
      end
    end
  endtask

  task automatic test_invalid();
    arm();
    tick(1'b0, 1'b1, 4'd0);
    n_cmp++;
    if ({invalid, armed} !== 2'b11) begin n_bad++; $display("FAIL invalid_pulse: got %b want 11", {invalid, armed}); end
    tick(1'b0, 1'b0, 4'd0);
    n_cmp++;
    if ({invalid, armed} !== 2'b01 || dut_obs !== m_exp()) begin
      n_bad++; $display("FAIL invalid_once: got %h want %h", dut_obs, m_exp());
    end
    tick(1'b0, 1'b1, 4'd12);
    n_cmp++;
    if ({invalid, armed} !== 2'b11) begin n_bad++; $display("FAIL invalid_key12: got %b want 11", {invalid, armed}); end
    tick(1'b0, 1'b1, 4'd3);
    tick(1'b0, 1'b0, 4'd0);
    n_cmp++;
    if ({result, score_b} !== {2'b10, 4'd1}) begin
      n_bad++; $display("FAIL b_win_after_invalid: got %h want %h", {result, score_b}, {2'b10, 4'd1});
    end
  endtask

  task automatic test_ready_start_same();
    arm();
    tick(1'b1, 1'b1, 4'd2);
    tick(1'b0, 1'b0, 4'd0);
    n_cmp++;
    if (result !== 2'b01 || dut_obs !== m_exp()) begin
      n_bad++; $display("FAIL ready_start_same: got %h want %h", dut_obs, m_exp());
    end
  endtask

  task automatic test_game_over();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      arm();
      tick(1'b0, 1'b1, 4'd3);
      tick(1'b0, 1'b0, 4'd0);
    end
    n_cmp++;
    if ({game_over, winner, score_b} !== {1'b1, 2'b10, 4'd3}) begin
      n_bad++; $display("FAIL game_over: got %h want %h", {game_over, winner, score_b}, {1'b1, 2'b10, 4'd3});
    end
    for (int i = 0; i < 12; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'(1 + $urandom_range(0, 8)));
    n_cmp++;
    if ({game_over, winner, score_b, round_cnt, armed} !== {1'b1, 2'b10, 4'd3, 4'd3, 1'b0}) begin
      n_bad++; $display("FAIL over_frozen: got %h want %h", {game_over, winner, score_b, round_cnt, armed}, {1'b1, 2'b10, 4'd3, 4'd3, 1'b0});
    end
    do_reset();
    n_cmp++;
    if (dut_obs !== 19'd0) begin n_bad++; $display("FAIL over_reset: got %h want 0", dut_obs); end
  endtask

`ifdef RPS_ROUND_HIST_EN
  task automatic test_hist();
    logic [3:0] keys [4] = '{4'd2, 4'd3, 4'd5, 4'd7};
    do_reset();
    for (int r = 0; r < 4; r++) begin
      arm();
      tick(1'b0, 1'b1, 4'd0);
      tick(1'b0, 1'b1, keys[r]);
      tick(1'b0, 1'b0, 4'd0);
    end
    n_cmp++;
    if (hist[7:0] !== 8'b01_10_11_01 || hist !== m_hist) begin
      n_bad++; $display("FAIL hist_order: got %h want %h", hist, m_hist);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] k;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ((m_mode == M_OVER && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        k = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'(1 + $urandom_range(0, 8));
        tick(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0), k);
      end
      n_cmp++;
      if (dut_obs !== m_exp()) begin
        n_bad++; $display("FAIL random_cycle_%0d: got %h want %h", i, dut_obs, m_exp());
      end
`ifdef RPS_ROUND_HIST_EN
      n_cmp++;
      if (hist !== m_hist) begin
        n_bad++; $display("FAIL random_hist_%0d: got %h want %h", i, hist, m_hist);
      end
`endif
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_a_wins();
    test_show_hold();
    test_draws();
    test_invalid();
    test_ready_start_same();
    test_game_over();
`ifdef RPS_ROUND_HIST_EN
    test_hist();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
